// File: rtl/pwm_breath_multi.sv
// Multi-channel PWM LED driver with per-channel off/fixed/breathing/phased-breathing modes; PWM_BREATH_GAMMA_EN squares the breathing level.
// Outputs registered one clock behind the counter; duty changes only at period wrap; config port has no backpressure.
module pwm_breath_multi #(
  parameter int CH       = 8,
  parameter int W        = 8,
  parameter int PRE_PWM  = 6,
  parameter int PRE_RAMP = 18,
  parameter int STEP     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [3:0]    cfg_ch,
  input  logic [1:0]    cfg_mode,
  input  logic [W-1:0]  cfg_duty,
  output logic [CH-1:0] pwm_out,
  output logic          period_start
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_FIXED  = 2'd1,
    MODE_BREATH = 2'd2,
    MODE_PHASE  = 2'd3
  } mode_e;

  localparam int         PHASE_STEP = (2 ** (W + 1)) / CH;
  localparam logic [W:0] STEP_V     = (W + 1)'(STEP);

  logic pwm_tick;
  logic ramp_tick;

  generate
    if (PRE_PWM == 0) begin : g_pwm_nopre
      assign pwm_tick = 1'b1;
    end else begin : g_pwm_pre
      logic [PRE_PWM-1:0] pre_q, pre_d;
      always_comb pre_d = pre_q + 1'b1;
      always_ff @(posedge clk) begin
        if (rst) pre_q <= '0;
        else     pre_q <= pre_d;
      end
      assign pwm_tick = &pre_q;
    end

    if (PRE_RAMP == 0) begin : g_ramp_nopre
      assign ramp_tick = 1'b1;
    end else begin : g_ramp_pre
      logic [PRE_RAMP-1:0] pre_q, pre_d;
      always_comb pre_d = pre_q + 1'b1;
      always_ff @(posedge clk) begin
        if (rst) pre_q <= '0;
        else     pre_q <= pre_d;
      end
      assign ramp_tick = &pre_q;
    end
  endgenerate

  // Triangle fold of the ramp, optionally squared for perceptual brightness.
  function automatic logic [W-1:0] breath_lvl(input logic [W:0] r);
    logic [W-1:0] l;
    l = r[W-1:0] ^ {W{r[W]}};
`ifdef PWM_BREATH_GAMMA_EN
    return W'(((2 * W)'(l) * (2 * W)'(l)) >> W);
`else
    return l;
`endif
  endfunction

  logic [W-1:0]  cnt_q, cnt_d;
  logic [W:0]    ramp_q, ramp_d;
  mode_e         mode_q     [CH];
  mode_e         mode_d     [CH];
  logic [W-1:0]  duty_cfg_q [CH];
  logic [W-1:0]  duty_cfg_d [CH];
  logic [W-1:0]  duty_act_q [CH];
  logic [W-1:0]  duty_act_d [CH];
  logic [W-1:0]  tgt        [CH];
  logic [CH-1:0] pwm_q, pwm_d;
  logic          period_start_q, period_start_d;
  logic          wrap;

  assign wrap = pwm_tick && (cnt_q == '1);

  always_comb begin
    cnt_d  = cnt_q;
    ramp_d = ramp_q;
    if (pwm_tick)  cnt_d  = cnt_q + 1'b1;
    if (ramp_tick) ramp_d = ramp_q + STEP_V;
  end

  // Targets are taken from the next-state config so a write landing on wrap is used immediately.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      mode_d[i]     = mode_q[i];
      duty_cfg_d[i] = duty_cfg_q[i];
      if (cfg_we && (cfg_ch == 4'(i))) begin
        mode_d[i]     = mode_e'(cfg_mode);
        duty_cfg_d[i] = cfg_duty;
      end
      case (mode_d[i])
        MODE_FIXED:  tgt[i] = duty_cfg_d[i];
        MODE_BREATH: tgt[i] = breath_lvl(ramp_q);
        MODE_PHASE:  tgt[i] = breath_lvl(ramp_q + (W + 1)'(i * PHASE_STEP));
        default:     tgt[i] = '0;
      endcase
      duty_act_d[i] = wrap ? tgt[i] : duty_act_q[i];
      pwm_d[i]      = (cnt_q < duty_act_q[i]);
    end
    period_start_d = wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      ramp_q         <= '0;
      pwm_q          <= '0;
      period_start_q <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        mode_q[i]     <= MODE_OFF;
        duty_cfg_q[i] <= '0;
        duty_act_q[i] <= '0;
      end
    end else begin
      cnt_q          <= cnt_d;
      ramp_q         <= ramp_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
      for (int i = 0; i < CH; i++) begin
        mode_q[i]     <= mode_d[i];
        duty_cfg_q[i] <= duty_cfg_d[i];
        duty_act_q[i] <= duty_act_d[i];
      end
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_breath_multi.sv
// Scoreboard bench for pwm_breath_multi: a time-arithmetic reference model queues expected outputs per clock, a monitor compares.
module tb_pwm_breath_multi;
  localparam int W        = 4;
  localparam int CH       = 4;
  localparam int PRE_PWM  = 0;
  localparam int PRE_RAMP = 2;
  localparam int STEP     = 4;
  localparam int P        = 2 ** W;
  localparam int RMOD     = 2 ** (W + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [3:0]    cfg_ch;
  logic [1:0]    cfg_mode;
  logic [W-1:0]  cfg_duty;
  logic [CH-1:0] pwm_out;
  logic          period_start;

  pwm_breath_multi #(
    .CH(CH), .W(W), .PRE_PWM(PRE_PWM), .PRE_RAMP(PRE_RAMP), .STEP(STEP)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_duty(cfg_duty), .pwm_out(pwm_out), .period_start(period_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH-1:0] pwm;
    logic          ps;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: clocks since reset plus the programmed and latched duties.
  int n_m = 0;
  int mode_m  [CH];
  int dutyc_m [CH];
  int act_m   [CH];

  function automatic int shape(input int r);
    int l;
    r = r % RMOD;
    l = (r < P) ? r : (RMOD - 1 - r);
`ifdef PWM_BREATH_GAMMA_EN
    l = (l * l) / P;
`endif
    return l;
  endfunction

  function automatic int target(input int m, input int d, input int ch, input int ramp);
    case (m)
      1:       return d;
      2:       return shape(ramp);
      3:       return shape(ramp + ch * (RMOD / CH));
      default: return 0;
    endcase
  endfunction

  task automatic model_step();
    exp_t e;
    int   cnt;
    int   ramp;
    if (rst) begin
      e.pwm = '0;
      e.ps  = 1'b0;
      n_m   = 0;
      for (int i = 0; i < CH; i++) begin
        mode_m[i] = 0; dutyc_m[i] = 0; act_m[i] = 0;
      end
    end else begin
      cnt  = n_m % P;
      ramp = ((n_m / (2 ** PRE_RAMP)) * STEP) % RMOD;
      if (cfg_we && int'(cfg_ch) < CH) begin
        mode_m[cfg_ch]  = int'(cfg_mode);
        dutyc_m[cfg_ch] = int'(cfg_duty);
      end
      for (int i = 0; i < CH; i++) e.pwm[i] = (cnt < act_m[i]);
      e.ps = (cnt == P - 1);
      if (cnt == P - 1)
        for (int i = 0; i < CH; i++) act_m[i] = target(mode_m[i], dutyc_m[i], i, ramp);
      n_m++;
    end
    q.push_back(e);
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (pwm_out !== e.pwm) begin
        errors++;
        if (errors < 30) $display("FAIL pwm_out t=%0t got %b want %b", $time, pwm_out, e.pwm);
      end
      checks++;
      if (period_start !== e.ps) begin
        errors++;
        if (errors < 30) $display("FAIL period_start t=%0t got %b want %b", $time, period_start, e.ps);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int ch, input int m, input int d);
    cfg_we   = 1'b1;
    cfg_ch   = 4'(ch);
    cfg_mode = 2'(m);
    cfg_duty = W'(d);
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  task automatic wait_phase(input int p);
    for (int k = 0; k <= P && (n_m % P) != p; k++) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_duty = '0;
    idle(3);
    rst = 1'b0;
    idle(40);
    wait_phase(5);  wr(1, 1, 5);   idle(40);
    wait_phase(3);  wr(0, 1, 0);   idle(36);
    wr(0, 1, 15);   idle(40);
    for (int c = 0; c < CH; c++) wr(c, 2, 0);
    idle(P * 10);
    rst = 1'b1; idle(1); rst = 1'b0;
    for (int c = 0; c < CH; c++) wr(c, 3, 0);
    idle(P * 12);
    wait_phase(15); wr(2, 1, 9);   idle(40);
    wait_phase(15); wr(3, 0, 0);   idle(20);
    wr(5, 1, 3);    idle(40);
    wait_phase(7);  rst = 1'b1; idle(1); rst = 1'b0;
    idle(20);
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1; idle(1); rst = 1'b0;
      end
      wr($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, P - 1));
      idle($urandom_range(0, 40));
    end
    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
